sigstream: RTL and testbench

- Producer end of the interleaved antenna stream that feeds the correlator's signal-source selector.
- Accepts one raw IQ antenna sample (all WIDTH antennas) per input handshake.
- Replays each sample for TRATE consecutive cycles with a time-address 0..TRATE-1, so the downstream selector can pick a different antenna pair each cycle.
- Frames samples into correlation blocks of COUNT samples using the first/next/last flags.

---
 rtl/sigstream_pkg.sv | 19 +
 rtl/sigstream_sigbuffer.sv | 48 ++++
 rtl/sigstream.sv | 115 +++++++++++
 tb/tb_sigstream.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sigstream_pkg.sv
// Constants shared by both ends of the interleaved antenna stream
// (this producer and the correlator's signal-source selector).
package sigstream_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_TRATE = 30;
    localparam int DEF_COUNT = 16;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_t;

    // Counter width for a modulus of n; at least one bit so n=1 still builds.
    function automatic int addr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sigstream_sigbuffer.sv
// One-entry pending (skid) register for the next IQ sample.
// Ready is registered and reflects whether the slot will be free next cycle.
module sigstream_sigbuffer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_wr,
    input  logic             i_rd,
    input  logic [WIDTH-1:0] i_idata,
    input  logic [WIDTH-1:0] i_qdata,
    output logic             o_full,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_idata,
    output logic [WIDTH-1:0] o_qdata
);

    logic             r_full;
    logic             r_ready;
    logic [WIDTH-1:0] r_idata;
    logic [WIDTH-1:0] r_qdata;
    logic             w_full_nxt;

    // A pop and a refill in the same cycle leave the slot occupied.
    assign w_full_nxt = i_wr | (r_full & ~i_rd);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_full  <= 1'b0;
            r_ready <= 1'b0;
            r_idata <= '0;
            r_qdata <= '0;
        end else begin
            r_full  <= w_full_nxt;
            r_ready <= ~w_full_nxt;
            if (i_wr) begin
                r_idata <= i_idata;
                r_qdata <= i_qdata;
            end
        end
    end

    assign o_full  = r_full;
    assign o_ready = r_ready;
    assign o_idata = r_idata;
    assign o_qdata = r_qdata;

endmodule

// File: rtl/sigstream.sv
// Replays each accepted IQ antenna sample for TRATE cycles with a time address,
// framing samples into blocks of COUNT via first/next/last.
module sigstream
    import sigstream_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int TRATE = DEF_TRATE,
    parameter  int COUNT = DEF_COUNT,
    localparam int TBITS = addr_bits(TRATE)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] idata_i,
    input  logic [WIDTH-1:0] qdata_i,
    output logic             valid_o,
    output logic             first_o,
    output logic             next_o,
    output logic             last_o,
    output logic [TBITS-1:0] taddr_o,
    output logic [WIDTH-1:0] idata_o,
    output logic [WIDTH-1:0] qdata_o
);

    localparam int CBITS = addr_bits(COUNT);

    state_t           r_state;
    logic [TBITS-1:0] r_tcnt;
    logic [CBITS-1:0] r_bcnt;
    logic [WIDTH-1:0] r_idata;
    logic [WIDTH-1:0] r_qdata;

    logic             w_ready;
    logic             w_hs;
    logic             w_emit;
    logic             w_end;
    logic             w_full;
    logic             w_wr;
    logic             w_rd;
    logic [WIDTH-1:0] w_pidata;
    logic [WIDTH-1:0] w_pqdata;

    assign w_hs   = valid_i & w_ready;
    assign w_emit = (r_state == ST_EMIT);
    assign w_end  = w_emit & (r_tcnt == TBITS'(TRATE - 1));

    // On the final cycle with an empty slot the input bypasses pending entirely.
    assign w_wr = w_hs & w_emit & ~(w_end & ~w_full);
    assign w_rd = w_end & w_full;

    sigstream_sigbuffer #(
        .WIDTH (WIDTH)
    ) u_sigbuffer (
        .clock   (clock),
        .reset_n (reset_n),
        .i_wr    (w_wr),
        .i_rd    (w_rd),
        .i_idata (idata_i),
        .i_qdata (qdata_i),
        .o_full  (w_full),
        .o_ready (w_ready),
        .o_idata (w_pidata),
        .o_qdata (w_pqdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_tcnt  <= '0;
            r_bcnt  <= '0;
            r_idata <= '0;
            r_qdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_idata <= idata_i;
                        r_qdata <= qdata_i;
                        r_tcnt  <= '0;
                        r_state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (!w_end) begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end else begin
                        r_tcnt <= '0;
                        r_bcnt <= (r_bcnt == CBITS'(COUNT - 1)) ? '0 : r_bcnt + 1'b1;
                        if (w_full) begin
                            r_idata <= w_pidata;
                            r_qdata <= w_pqdata;
                        end else if (w_hs) begin
                            r_idata <= idata_i;
                            r_qdata <= qdata_i;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready_o = w_ready;
    assign valid_o = w_emit;
    assign taddr_o = r_tcnt;
    assign idata_o = r_idata;
    assign qdata_o = r_qdata;
    assign first_o = w_emit & (r_tcnt == '0) & (r_bcnt == '0);
    assign next_o  = w_end;
    assign last_o  = w_end & (r_bcnt == CBITS'(COUNT - 1));

endmodule

// File: tb/tb_sigstream.sv
// Scoreboard bench for sigstream: each accepted sample expands into TRATE expected beats.
module tb_sigstream;

    localparam int WIDTH = 4;
    localparam int TRATE = 3;
    localparam int COUNT = 2;
    localparam int TBITS = 2;

    logic             clock;
    logic             reset_n;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] idata_i;
    logic [WIDTH-1:0] qdata_i;
    logic             valid_o;
    logic             first_o;
    logic             next_o;
    logic             last_o;
    logic [TBITS-1:0] taddr_o;
    logic [WIDTH-1:0] idata_o;
    logic [WIDTH-1:0] qdata_o;

    typedef struct {
        logic [TBITS-1:0] t;
        logic             f;
        logic             n;
        logic             l;
        logic [WIDTH-1:0] i;
        logic [WIDTH-1:0] q;
    } beat_t;

    beat_t exp_q[$];
    int    nsamp;
    int    checks;
    int    failures;

    sigstream #(
        .WIDTH (WIDTH),
        .TRATE (TRATE),
        .COUNT (COUNT)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .idata_i (idata_i),
        .qdata_i (qdata_i),
        .valid_o (valid_o),
        .first_o (first_o),
        .next_o  (next_o),
        .last_o  (last_o),
        .taddr_o (taddr_o),
        .idata_o (idata_o),
        .qdata_o (qdata_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor + reference model: one beat per cycle while any accepted sample remains.
    always @(negedge clock) begin
        beat_t b;
        if (!reset_n) begin
            chk("reset_outs", 32'({valid_o, first_o, next_o, last_o, taddr_o, idata_o, qdata_o, ready_o}), 32'd0);
            exp_q.delete();
            nsamp = 0;
        end else begin
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_valid actual=valid required=idle t=%0t", $time);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat", 32'({taddr_o, first_o, next_o, last_o, idata_o, qdata_o}),
                        32'({b.t, b.f, b.n, b.l, b.i, b.q}));
                end
            end else begin
                chk("gap_with_pending", 32'(exp_q.size()), 32'd0);
                chk("idle_outs", 32'({first_o, next_o, last_o, taddr_o}), 32'd0);
            end
            if (valid_i && ready_o) begin
                for (int t = 0; t < TRATE; t++) begin
                    b.t = TBITS'(t);
                    b.f = (t == 0) && (nsamp % COUNT == 0);
                    b.n = (t == TRATE - 1);
                    b.l = (t == TRATE - 1) && (nsamp % COUNT == COUNT - 1);
                    b.i = idata_i;
                    b.q = qdata_i;
                    exp_q.push_back(b);
                end
                nsamp++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] i, input logic [WIDTH-1:0] q);
        logic got;
        idata_i = i;
        qdata_i = q;
        valid_i = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clock);
            got = ready_o;
            @(posedge clock);
            #1;
        end
        valid_i = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not_accepted required=accepted t=%0t", $time);
        end
    endtask

    task automatic rst_pulse();
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(1);
    endtask

    initial begin
        logic hit;
        checks   = 0;
        failures = 0;
        nsamp    = 0;
        reset_n  = 1'b0;
        valid_i  = 1'b0;
        idata_i  = '0;
        qdata_i  = '0;

        idle(3);
        reset_n = 1'b1;
        @(negedge clock);
        chk("ready_before_edge", 32'(ready_o), 32'd0);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("ready_after_edge", 32'(ready_o), 32'd1);
        @(posedge clock);
        #1;

        // Single sample
        send(4'hA, 4'h5);
        idle(6);

        // Back-to-back stream of four samples
        rst_pulse();
        for (int s = 0; s < 4; s++) send(4'($urandom), 4'($urandom));
        idle(16);

        // Sample, gap, sample: block spans the gap
        rst_pulse();
        send(4'h3, 4'hC);
        idle(5);
        send(4'h6, 4'h9);
        idle(6);

        // Async reset in the middle of S1
        rst_pulse();
        fork
            begin
                for (int s = 0; s < 4; s++) send(4'($urandom), 4'($urandom));
            end
            begin
                int seen;
                seen = 0;
                hit  = 1'b0;
                for (int k = 0; k < 40 && !hit; k++) begin
                    @(negedge clock);
                    if (valid_o && next_o) seen++;
                    else if (seen == 1 && valid_o && taddr_o == 1) hit = 1'b1;
                end
                chk("midrun_trigger_found", 32'(hit), 32'd1);
                #2;
                reset_n = 1'b0;
                #1;
                chk("async_reset_outs", 32'({valid_o, first_o, next_o, last_o, taddr_o, idata_o, qdata_o}), 32'd0);
                @(posedge clock);
                @(posedge clock);
                #1;
                reset_n = 1'b1;
            end
        join
        idle(20);

        // Bypass: handshake on the final cycle with pending empty
        rst_pulse();
        send(4'h1, 4'hE);
        idle(2);
        send(4'h7, 4'h8);
        @(negedge clock);
        chk("bypass_ready", 32'(ready_o), 32'd1);
        @(posedge clock);
        #1;
        idle(6);

        // Randomized traffic
        for (int r = 0; r < 200; r++) begin
            if ($urandom_range(0, 2) != 0) send(4'($urandom), 4'($urandom));
            else idle($urandom_range(1, 4));
        end
        idle(20);
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
